decode_unit: RTL and testbench

//  RV32I ID stage between fetch_unit (IF/ID latches) and the execute stage.

---
 rtl/decode_unit.sv | 216 +++++++++++++++++++++
 tb/tb_decode_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_unit.sv
// RV32I ID stage: decodes IF/ID, forms immediates/controls, detects load-use hazards, registers ID/EX.
// Latency 1 cycle; ID_stall (load-use or EX_stall, dropped on ID_flush) holds fetch; EX_stall holds the latch.
// DECODE_RV32M_EN enables MUL..REMU decode for OP with funct7=0000001.
module decode_unit #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] IF_ID_PC,
    input  logic [31:0]     IF_ID_instr,
    input  logic            IF_Valid,
    input  logic            ID_flush,
    input  logic            EX_stall,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            ID_stall,
    output logic [XLEN-1:0] ID_EX_PC,
    output logic [XLEN-1:0] ID_EX_rs1_data,
    output logic [XLEN-1:0] ID_EX_rs2_data,
    output logic [XLEN-1:0] ID_EX_imm,
    output logic [4:0]      ID_EX_rd,
    output logic [4:0]      ID_EX_rs1,
    output logic [4:0]      ID_EX_rs2,
    output logic [4:0]      ID_EX_alu_op,
    output logic            ID_EX_src_pc,
    output logic            ID_EX_src_imm,
    output logic            ID_EX_mem_read,
    output logic            ID_EX_mem_write,
    output logic            ID_EX_reg_write,
    output logic            ID_EX_branch,
    output logic            ID_EX_jump,
    output logic [2:0]      ID_EX_funct3,
    output logic            ID_EX_illegal,
    output logic            ID_EX_Valid
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [4:0] ALU_ADD   = 5'd0;
    localparam logic [4:0] ALU_SUB   = 5'd1;
    localparam logic [4:0] ALU_PASSB = 5'd10;

    typedef struct packed {
        logic [4:0] alu_op;
        logic       src_pc;
        logic       src_imm;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       jump;
        logic [2:0] funct3;
        logic       illegal;
    } ctrl_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm32;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        hazard;
    ctrl_t       dec;
    ctrl_t       ctrl_q;

    assign opcode   = IF_ID_instr[6:0];
    assign rd       = IF_ID_instr[11:7];
    assign funct3   = IF_ID_instr[14:12];
    assign funct7   = IF_ID_instr[31:25];
    assign rs1_addr = IF_ID_instr[19:15];
    assign rs2_addr = IF_ID_instr[24:20];

    // funct3 ordering shared by OP and OP-IMM; alt selects SUB/SRA
    function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    base_alu = alt ? ALU_SUB : ALU_ADD;
            3'd1:    base_alu = 5'd2;
            3'd2:    base_alu = 5'd3;
            3'd3:    base_alu = 5'd4;
            3'd4:    base_alu = 5'd5;
            3'd5:    base_alu = alt ? 5'd7 : 5'd6;
            3'd6:    base_alu = 5'd8;
            default: base_alu = 5'd9;
        endcase
    endfunction

    always_comb begin
        dec        = '0;
        dec.funct3 = funct3;
        imm32      = '0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec.alu_op = ALU_PASSB; dec.src_imm = 1'b1; dec.reg_write = 1'b1;
                imm32 = {IF_ID_instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                dec.src_pc = 1'b1; dec.src_imm = 1'b1; dec.reg_write = 1'b1;
                imm32 = {IF_ID_instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                dec.jump = 1'b1; dec.reg_write = 1'b1; dec.src_pc = 1'b1; dec.src_imm = 1'b1;
                imm32 = {{12{IF_ID_instr[31]}}, IF_ID_instr[19:12], IF_ID_instr[20],
                         IF_ID_instr[30:21], 1'b0};
            end
            OPC_JALR: begin
                dec.jump = 1'b1; dec.reg_write = 1'b1; dec.src_imm = 1'b1;
                imm32 = {{20{IF_ID_instr[31]}}, IF_ID_instr[31:20]};
                uses_rs1 = 1'b1;
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1; dec.alu_op = ALU_SUB;
                imm32 = {{20{IF_ID_instr[31]}}, IF_ID_instr[7], IF_ID_instr[30:25],
                         IF_ID_instr[11:8], 1'b0};
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                dec.mem_read = 1'b1; dec.reg_write = 1'b1; dec.src_imm = 1'b1;
                imm32 = {{20{IF_ID_instr[31]}}, IF_ID_instr[31:20]};
                uses_rs1 = 1'b1;
            end
            OPC_STORE: begin
                dec.mem_write = 1'b1; dec.src_imm = 1'b1;
                imm32 = {{20{IF_ID_instr[31]}}, IF_ID_instr[31:25], IF_ID_instr[11:7]};
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                dec.src_imm = 1'b1; dec.reg_write = 1'b1;
                imm32 = {{20{IF_ID_instr[31]}}, IF_ID_instr[31:20]};
                uses_rs1 = 1'b1;
                dec.alu_op = base_alu(funct3, (funct3 == 3'd5) && funct7[5]);
                if ((funct3 == 3'd1 && funct7 != 7'h00) ||
                    (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20))
                    dec.illegal = 1'b1;
            end
            OPC_OP: begin
                dec.reg_write = 1'b1;
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                if (funct7 == 7'h00)
                    dec.alu_op = base_alu(funct3, 1'b0);
                else if (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))
                    dec.alu_op = base_alu(funct3, 1'b1);
`ifdef DECODE_RV32M_EN
                else if (funct7 == 7'h01)
                    dec.alu_op = 5'd11 + {2'b00, funct3};
`endif
                else
                    dec.illegal = 1'b1;
            end
            OPC_FENCE: ;
            default: dec.illegal = 1'b1;
        endcase
        // an undecodable word must not touch memory, registers or control flow
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        if (rd == 5'd0 || IF_ID_instr == NOP_INSN)
            dec.reg_write = 1'b0;
    end

    assign hazard = IF_Valid & ID_EX_Valid & ctrl_q.mem_read & (ID_EX_rd != 5'd0) &
                    ((uses_rs1 & (rs1_addr == ID_EX_rd)) | (uses_rs2 & (rs2_addr == ID_EX_rd)));
    assign ID_stall = (hazard | EX_stall) & ~ID_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ID_EX_Valid    <= 1'b0;
            ctrl_q         <= '0;
            ID_EX_PC       <= '0;
            ID_EX_rs1_data <= '0;
            ID_EX_rs2_data <= '0;
            ID_EX_imm      <= '0;
            ID_EX_rd       <= '0;
            ID_EX_rs1      <= '0;
            ID_EX_rs2      <= '0;
        end else if (ID_flush) begin
            ID_EX_Valid <= 1'b0;
            ctrl_q      <= '0;
        end else if (!EX_stall) begin
            ID_EX_Valid    <= IF_Valid & ~hazard;
            ctrl_q         <= (IF_Valid & ~hazard) ? dec : '0;
            ID_EX_PC       <= IF_ID_PC;
            ID_EX_rs1_data <= rs1_data;
            ID_EX_rs2_data <= rs2_data;
            ID_EX_imm      <= XLEN'($signed(imm32));
            ID_EX_rd       <= rd;
            ID_EX_rs1      <= rs1_addr;
            ID_EX_rs2      <= rs2_addr;
        end
    end

    assign ID_EX_alu_op    = ctrl_q.alu_op;
    assign ID_EX_src_pc    = ctrl_q.src_pc;
    assign ID_EX_src_imm   = ctrl_q.src_imm;
    assign ID_EX_mem_read  = ctrl_q.mem_read;
    assign ID_EX_mem_write = ctrl_q.mem_write;
    assign ID_EX_reg_write = ctrl_q.reg_write;
    assign ID_EX_branch    = ctrl_q.branch;
    assign ID_EX_jump      = ctrl_q.jump;
    assign ID_EX_funct3    = ctrl_q.funct3;
    assign ID_EX_illegal   = ctrl_q.illegal;
endmodule

// File: tb/tb_decode_unit.sv
// Randomized bench for decode_unit against a spec-level decode and pipeline-latch model.
module tb_decode_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IF_ID_PC, IF_ID_instr;
    logic        IF_Valid, ID_flush, EX_stall;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        ID_stall;
    logic [31:0] ID_EX_PC, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
    logic [4:0]  ID_EX_rd, ID_EX_rs1, ID_EX_rs2, ID_EX_alu_op;
    logic        ID_EX_src_pc, ID_EX_src_imm, ID_EX_mem_read, ID_EX_mem_write;
    logic        ID_EX_reg_write, ID_EX_branch, ID_EX_jump, ID_EX_illegal, ID_EX_Valid;
    logic [2:0]  ID_EX_funct3;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [32];
    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    always #5 clk = ~clk;

    decode_unit dut (
        .clk(clk), .reset(reset), .IF_ID_PC(IF_ID_PC), .IF_ID_instr(IF_ID_instr),
        .IF_Valid(IF_Valid), .ID_flush(ID_flush), .EX_stall(EX_stall),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ID_stall(ID_stall), .ID_EX_PC(ID_EX_PC), .ID_EX_rs1_data(ID_EX_rs1_data),
        .ID_EX_rs2_data(ID_EX_rs2_data), .ID_EX_imm(ID_EX_imm), .ID_EX_rd(ID_EX_rd),
        .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_alu_op(ID_EX_alu_op),
        .ID_EX_src_pc(ID_EX_src_pc), .ID_EX_src_imm(ID_EX_src_imm),
        .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_mem_write(ID_EX_mem_write),
        .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_branch(ID_EX_branch),
        .ID_EX_jump(ID_EX_jump), .ID_EX_funct3(ID_EX_funct3),
        .ID_EX_illegal(ID_EX_illegal), .ID_EX_Valid(ID_EX_Valid)
    );

    typedef struct packed {
        logic [4:0] alu_op;
        logic       src_pc, src_imm, mem_read, mem_write, reg_write, branch, jump;
        logic [2:0] funct3;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        logic        valid;
        logic        dk;      // data fields are defined (not a bubble)
        ctl_t        ctl;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  rd, rs1, rs2;
    } st_t;

    st_t  m;
    ctl_t dut_ctl;
    assign dut_ctl = {ID_EX_alu_op, ID_EX_src_pc, ID_EX_src_imm, ID_EX_mem_read, ID_EX_mem_write,
                      ID_EX_reg_write, ID_EX_branch, ID_EX_jump, ID_EX_funct3, ID_EX_illegal};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] ins, output ctl_t c,
                                       output logic [31:0] imm, output logic u1, output logic u2);
        logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        int          op;
        int          op_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        f3    = ins[14:12];
        f7    = ins[31:25];
        i_imm = 32'($signed(ins) >>> 20);
        s_imm = {i_imm[31:5], ins[11:7]};
        b_imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        u_imm = ins & 32'hFFFF_F000;
        j_imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        c = '0; c.funct3 = f3; imm = 32'd0; u1 = 1'b0; u2 = 1'b0; op = 0;
        case (ins[6:0])
            7'h37: begin c.reg_write = 1; c.src_imm = 1; op = 10; imm = u_imm; end
            7'h17: begin c.reg_write = 1; c.src_imm = 1; c.src_pc = 1; imm = u_imm; end
            7'h6F: begin c.reg_write = 1; c.src_imm = 1; c.src_pc = 1; c.jump = 1; imm = j_imm; end
            7'h67: begin c.reg_write = 1; c.src_imm = 1; c.jump = 1; imm = i_imm; u1 = 1; end
            7'h63: begin c.branch = 1; op = 1; imm = b_imm; u1 = 1; u2 = 1; end
            7'h03: begin c.mem_read = 1; c.reg_write = 1; c.src_imm = 1; imm = i_imm; u1 = 1; end
            7'h23: begin c.mem_write = 1; c.src_imm = 1; imm = s_imm; u1 = 1; u2 = 1; end
            7'h13: begin
                c.reg_write = 1; c.src_imm = 1; imm = i_imm; u1 = 1;
                op = op_tab[f3];
                if (f3 == 1 && f7 != 0) op = -1;
                if (f3 == 5) op = (f7 == 0) ? 6 : (f7 == 7'h20) ? 7 : -1;
            end
            7'h33: begin
                c.reg_write = 1; u1 = 1; u2 = 1;
                if (f7 == 0) op = op_tab[f3];
                else if (f7 == 7'h20 && f3 == 0) op = 1;
                else if (f7 == 7'h20 && f3 == 5) op = 7;
`ifdef DECODE_RV32M_EN
                else if (f7 == 7'h01) op = 11 + int'(f3);
`endif
                else op = -1;
            end
            7'h0F: ;
            default: op = -1;
        endcase
        if (op < 0) begin
            c = '0; c.illegal = 1;
        end else begin
            c.alu_op = 5'(op);
        end
        if (ins[11:7] == 0) c.reg_write = 0;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_vld"}, 64'(ID_EX_Valid), 64'(m.valid));
        check({tag, "_ctl"}, 64'(dut_ctl), 64'(m.ctl));
        if (m.dk) begin
            check({tag, "_pc"}, 64'(ID_EX_PC), 64'(m.pc));
            check({tag, "_imm"}, 64'(ID_EX_imm), 64'(m.imm));
            check({tag, "_opnd"}, {ID_EX_rs1_data, ID_EX_rs2_data}, {m.r1, m.r2});
            check({tag, "_regs"}, 64'({ID_EX_rd, ID_EX_rs1, ID_EX_rs2}), 64'({m.rd, m.rs1, m.rs2}));
        end
    endtask

    // one clock: drive at negedge, check combinational outputs, advance model, check latch
    task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                        input logic iv, input logic fl, input logic xs);
        ctl_t c; logic [31:0] imm; logic u1, u2, haz;
        @(negedge clk);
        IF_ID_instr = ins; IF_ID_PC = pc; IF_Valid = iv; ID_flush = fl; EX_stall = xs;
        #1;
        ref_decode(ins, c, imm, u1, u2);
        haz = iv && m.valid && m.ctl.mem_read && m.rd != 0 &&
              ((u1 && ins[19:15] == m.rd) || (u2 && ins[24:20] == m.rd));
        check({tag, "_addr"}, 64'({rs1_addr, rs2_addr}), 64'({ins[19:15], ins[24:20]}));
        check({tag, "_stall"}, 64'(ID_stall), 64'((haz || xs) && !fl));
        if (fl || (!xs && (haz || !iv))) begin
            m.valid = 0; m.ctl = '0; m.dk = 0;
        end else if (!xs) begin
            m.valid = 1; m.dk = 1; m.ctl = c; m.pc = pc; m.imm = imm;
            m.r1 = rf[ins[19:15]]; m.r2 = rf[ins[24:20]];
            m.rd = ins[11:7]; m.rs1 = ins[19:15]; m.rs2 = ins[24:20];
        end
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 12);
        case (k)
            0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;  3: w[6:0] = 7'h67;
            4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;  6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;
            8: w[6:0] = 7'h33;  9: w[6:0] = 7'h0F;  10: w[6:0] = 7'h03; 12: w[6:0] = 7'h33;
            default: ;
        endcase
        if (k != 11) begin
            w[11:7]  = 5'($urandom_range(0, 3));
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
        end
        if (k == 7 || k == 8 || k == 12) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: ;
            endcase
        end
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        reset = 1; IF_ID_PC = 0; IF_ID_instr = 0; IF_Valid = 0; ID_flush = 0; EX_stall = 0;
        m = '0; m.dk = 1;
        repeat (2) @(negedge clk);
        #1;
        compare_all("reset");
        check("reset_stall", 64'(ID_stall), 64'(0));
        reset = 0;

        step("addi", 32'h0050_0093, 32'h10, 1, 0, 0);
        check("addi_imm", 64'(ID_EX_imm), 64'h5);
        check("addi_rd", 64'({ID_EX_rd, ID_EX_reg_write, ID_EX_src_imm}), 64'({5'd1, 1'b1, 1'b1}));
        check("addi_op", 64'({ID_EX_alu_op, ID_EX_PC}), 64'({5'd0, 32'h10}));

        step("lw", 32'h0000_A103, 32'h14, 1, 0, 0);
        step("lu_haz", 32'h0021_01B3, 32'h18, 1, 0, 0);
        check("lu_bubble", 64'(ID_EX_Valid), 64'(0));
        step("lu_add", 32'h0021_01B3, 32'h18, 1, 0, 0);
        check("lu_add_rd", 64'({ID_EX_Valid, ID_EX_rd, ID_EX_mem_read}), 64'({1'b1, 5'd3, 1'b0}));

        step("beq", 32'hFE00_0EE3, 32'h1C, 1, 0, 0);
        check("beq_imm", 64'(ID_EX_imm), 64'hFFFF_FFFC);
        check("beq_ctl", 64'({ID_EX_branch, ID_EX_reg_write}), 64'({1'b1, 1'b0}));
        step("flush", 32'h0050_0093, 32'h20, 1, 1, 1);
        check("flush_vld", 64'(ID_EX_Valid), 64'(0));

        step("pre_hold", 32'h0050_0093, 32'h20, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("hold", 32'h00A0_0113, 32'h24, 1, 0, 1);
            check("hold_pc", 64'(ID_EX_PC), 64'h20);
        end
        step("release", 32'h00A0_0113, 32'h24, 1, 0, 0);
        check("release_pc", 64'(ID_EX_PC), 64'h24);

        step("mul", 32'h0220_81B3, 32'h28, 1, 0, 0);
`ifdef DECODE_RV32M_EN
        check("mul_op", 64'({ID_EX_alu_op, ID_EX_illegal, ID_EX_reg_write}), 64'({5'd11, 1'b0, 1'b1}));
`else
        check("mul_op", 64'({ID_EX_alu_op, ID_EX_illegal, ID_EX_reg_write}), 64'({5'd0, 1'b1, 1'b0}));
`endif

        for (int n = 0; n < 1500; n++)
            step("rnd", rand_insn(), $urandom & 32'hFFFF_FFFC,
                 ($urandom % 10) != 0, ($urandom % 20) == 0, ($urandom % 8) == 0);

        // asynchronous reset while a load-use stall is pending
        step("rst_bub", 32'h0000_0013, 32'h40, 0, 0, 0);
        step("rst_lw", 32'h0000_A103, 32'h44, 1, 0, 0);
        @(negedge clk);
        IF_ID_instr = 32'h0021_01B3; IF_ID_PC = 32'h48; IF_Valid = 1; ID_flush = 0; EX_stall = 0;
        #1;
        check("rst_pre_stall", 64'(ID_stall), 64'(1));
        #1 reset = 1;
        #1;
        m = '0; m.dk = 1;
        compare_all("rst_mid");
        check("rst_mid_stall", 64'(ID_stall), 64'(0));
        @(posedge clk);
        #1;
        compare_all("rst_hold");
        reset = 0;
        step("rst_idle", 32'h0050_0093, 32'h4C, 0, 0, 0);
        step("rst_first", 32'h0050_0093, 32'h50, 1, 0, 0);

        for (int n = 0; n < 300; n++)
            step("rnd2", rand_insn(), $urandom & 32'hFFFF_FFFC,
                 ($urandom % 10) != 0, ($urandom % 20) == 0, ($urandom % 8) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
